sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-ported, synchronous SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage CPU.
- Sits between the fetch/mem pipeline stages and the shared memory port.
- Grants at most one request per cycle, routes the one-cycle-latency read data back to its owner and holds it there.
- Data requests have priority; a bounded starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; legal range 1-15.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held until inst_gnt.
- inst_addr  in  ADDR_W  fetch address.
- inst_flush  in  1  cancel the in-flight fetch response (redirect).
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  fetch data valid, one-cycle pulse.
- inst_rdata  out  DATA_W  fetch data, held until the next inst response.
- data_req  in  1  data request; held until data_gnt.
- data_wr  in  1  1 = store, 0 = load.
- data_wen  in  DATA_W/8  byte enables for a store.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_rvalid  out  1  load data valid, one-cycle pulse; never asserted for stores.
- data_rdata  out  DATA_W  load data, held until the next load response.
- mem_en  out  1  shared port enable.
- mem_wen  out  DATA_W/8  shared port byte write enables.
- mem_addr  out  ADDR_W  shared port address.
- mem_wdata  out  DATA_W  shared port write data.
- mem_rdata  in  DATA_W  shared port read data, valid one cycle after mem_en with mem_wen == 0.

Behaviour:
- Arbitration is combinational in cycle t. Grant inputs:
  - starve_cnt register, 4 bits.
  - resp_owner register, encoded NONE/INST/DATA.
- Grant rules:
  - Only inst_req: grant inst.
  - Only data_req: grant data.
  - Both requests and starve_cnt < STARVE_MAX: grant data.
  - Both requests and starve_cnt == STARVE_MAX: grant inst.
- Exactly one of inst_gnt/data_gnt is high when any request is high; neither is high otherwise.
- Port drive:
  - mem_en = inst_gnt | data_gnt.
  - mem_addr/mem_wdata are muxed from the winner.
  - mem_wen = data_wen when data_gnt & data_wr, else 0.
  - All mem_* outputs are 0 when idle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when data_gnt & inst_req.
  - Clears when inst_gnt or !inst_req.
- resp_owner at the next edge:
  - INST if inst_gnt.
  - DATA if data_gnt & !data_wr.
  - Otherwise NONE.
- Response in cycle t+1, registered outputs:
  - owner INST: inst_rvalid = 1 and inst_rdata <= mem_rdata, unless inst_flush is high in t+1. A flush suppresses rvalid and leaves inst_rdata unchanged.
  - owner DATA: data_rvalid = 1 and data_rdata <= mem_rdata.
  - rdata registers are sticky. Both rvalid outputs are cleared every cycle they are not set.
- Back-to-back grants are legal every cycle. Throughput is one access per cycle and grant-to-rvalid latency is one cycle.
- inst_flush with no inst response outstanding has no effect. A flush never cancels a grant in the same cycle.
- Stores complete at data_gnt. A store followed by a load to the same address in the next cycle returns the new data (SRAM write-first not required; port ordering suffices).
- Reset, including mid-transaction:
  - All outputs and registers go to 0: gnt, rvalid, rdata, mem_*, starve_cnt = 0, resp_owner = NONE.
  - An outstanding response is dropped; no rvalid after reset deasserts.
- Request inputs changing while not granted is a requester protocol violation. It is not detected; the arbiter uses current values.

Decomposition:
- Shared package sram_arb_pkg holds:
  - owner encoding OWN_NONE = 2'd0, OWN_INST = 2'd1, OWN_DATA = 2'd2;
  - default STARVE_MAX;
  - the byte-enable width function DATA_W/8.
- One sub-module, arb_starve_cnt: saturating counter with inc/clr/sat outputs, parameterized by STARVE_MAX.
- The grant mux and response router stay in the top module.

Test Plan:
- Lone fetches:
  - Stimulus: inst_req with addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; mem_rdata returns 0x11, 0x22, 0x33.
  - Response: inst_gnt high three cycles; inst_rvalid pulses t+1..t+3; inst_rdata = 0x11, 0x22, 0x33.
- Starvation bound:
  - Stimulus: inst_req and data_req (loads) held high for 12 cycles, STARVE_MAX = 4.
  - Response: grant pattern D,D,D,D,I repeating; inst_gnt at cycles 5 and 10; starve_cnt never exceeds 4.
- Store/load:
  - Stimulus: data store addr 0x100, wen 4'b0011, wdata 0xAABBCCDD, then load 0x100.
  - Response: mem_wen = 0011 during the store cycle; no data_rvalid for the store; data_rvalid one cycle after the load grant.
- Flush:
  - Stimulus: inst granted at t; inst_flush = 1 at t+1 with mem_rdata = 0xDEAD.
  - Response: inst_rvalid stays 0; inst_rdata keeps its prior value.
- Reset mid-operation:
  - Stimulus: reset asserted asynchronously in the cycle after a data load grant.
  - Response: all outputs 0 immediately; no data_rvalid after release; first post-reset request granted normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : sram_arb_pkg
// Purpose : Shared constants and helpers for the SRAM port arbiter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_INST = 2'd1;
  localparam owner_t OWN_DATA = 2'd2;

  localparam int STARVE_MAX_DEFAULT = 4;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
//------------------------------------------------------------------------------
// Module  : arb_starve_cnt
// Purpose : Saturating count of data grants taken while fetch is waiting.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] C_MAX = 4'(STARVE_MAX);

  logic [3:0] r_cnt;

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("arb_starve_cnt: STARVE_MAX must be within 1..15");
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (clr) begin
      r_cnt <= 4'd0;
    end else if (inc && (r_cnt < C_MAX)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign sat = (r_cnt >= C_MAX);

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_port_arbiter
// Purpose : Shares one synchronous SRAM port between fetch and load/store.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inst_req,
  input  logic [ADDR_W-1:0]           inst_addr,
  input  logic                        inst_flush,
  output logic                        inst_gnt,
  output logic                        inst_rvalid,
  output logic [DATA_W-1:0]           inst_rdata,
  input  logic                        data_req,
  input  logic                        data_wr,
  input  logic [be_width(DATA_W)-1:0] data_wen,
  input  logic [ADDR_W-1:0]           data_addr,
  input  logic [DATA_W-1:0]           data_wdata,
  output logic                        data_gnt,
  output logic                        data_rvalid,
  output logic [DATA_W-1:0]           data_rdata,
  output logic                        mem_en,
  output logic [be_width(DATA_W)-1:0] mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int BE_W = be_width(DATA_W);

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("sram_port_arbiter: DATA_W must be a multiple of 8");
  end

  owner_t r_resp_owner;
  logic   w_starve_sat;
  logic   w_starve_inc;
  logic   w_starve_clr;

  // Data wins unless fetch has already waited out the full starvation budget.
  // Grants are held off while reset is asserted so every output reads 0.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      if (data_req && !(inst_req && w_starve_sat)) begin
        data_gnt = 1'b1;
      end else if (inst_req) begin
        inst_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (inst_gnt) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end else if (data_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wen   = data_wr ? data_wen : {BE_W{1'b0}};
    end
  end

  assign w_starve_inc = data_gnt & inst_req;
  assign w_starve_clr = inst_gnt | ~inst_req;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_starve_inc),
    .clr   (w_starve_clr),
    .sat   (w_starve_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_owner <= OWN_NONE;
    end else if (inst_gnt) begin
      r_resp_owner <= OWN_INST;
    end else if (data_gnt && !data_wr) begin
      r_resp_owner <= OWN_DATA;
    end else begin
      r_resp_owner <= OWN_NONE;
    end
  end

  // rdata registers only load on a delivered response; a flush keeps the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_rvalid <= 1'b0;
      inst_rdata  <= '0;
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      if ((r_resp_owner == OWN_INST) && !inst_flush) begin
        inst_rvalid <= 1'b1;
        inst_rdata  <= mem_rdata;
      end
      if (r_resp_owner == OWN_DATA) begin
        data_rvalid <= 1'b1;
        data_rdata  <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_port_arbiter
// Purpose : Randomized and directed self-checking bench for sram_port_arbiter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req, inst_flush, inst_gnt, inst_rvalid;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_gnt, data_rvalid;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h11;
      1:       return 32'h22;
      2:       return 32'h33;
      3:       return 32'hDEAD;
      default: return (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Synchronous memory behind the port; idle cycles return junk on mem_rdata.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

  always @(posedge clk) begin
    if (mem_en && (mem_wen == 4'b0000)) begin
      mem_rdata <= mem[mem_addr[9:2]];
    end else begin
      mem_rdata <= $urandom;
      if (mem_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: the memory contents as the requesters see them, the
  // response owed next cycle, and how many data grants fetch has sat through.
  logic [31:0] shadow [0:255];
  int          pend_kind;          // 0 none, 1 fetch, 2 load
  logic [31:0] pend_word;
  int          fetch_waited;
  logic        exp_irv, exp_drv;
  logic [31:0] exp_ird, exp_drd;
  logic        last_gi, last_gd;
  int          obs_inst_gnts;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_kind    = 0;
    pend_word    = '0;
    fetch_waited = 0;
    exp_irv      = 1'b0;
    exp_drv      = 1'b0;
    exp_ird      = '0;
    exp_drd      = '0;
  endtask

  task automatic check_outputs_zero(input string phase);
    chk({phase, " inst_gnt"},    inst_gnt,    0);
    chk({phase, " data_gnt"},    data_gnt,    0);
    chk({phase, " inst_rvalid"}, inst_rvalid, 0);
    chk({phase, " data_rvalid"}, data_rvalid, 0);
    chk({phase, " inst_rdata"},  inst_rdata,  0);
    chk({phase, " data_rdata"},  data_rdata,  0);
    chk({phase, " mem_en"},      mem_en,      0);
    chk({phase, " mem_wen"},     mem_wen,     0);
    chk({phase, " mem_addr"},    mem_addr,    0);
    chk({phase, " mem_wdata"},   mem_wdata,   0);
  endtask

  // One clock: check against the model at negedge, advance the model, then
  // return just after the next rising edge ready for new stimulus.
  task automatic cycle();
    logic        gi, gd;
    logic [31:0] word;
    int          ii, di;
    @(negedge clk);
    gi = 1'b0;
    gd = 1'b0;
    if (inst_req && data_req) begin
      if (fetch_waited >= SMAX) gi = 1'b1;
      else                      gd = 1'b1;
    end else begin
      gi = inst_req;
      gd = data_req;
    end
    chk("inst_gnt", inst_gnt, gi);
    chk("data_gnt", data_gnt, gd);
    chk("mem_en",   mem_en,   gi | gd);
    chk("mem_addr",  mem_addr,  gi ? inst_addr : (gd ? data_addr : '0));
    chk("mem_wdata", mem_wdata, gd ? data_wdata : '0);
    chk("mem_wen",   mem_wen,   (gd && data_wr) ? data_wen : 4'b0000);
    chk("inst_rvalid", inst_rvalid, exp_irv);
    chk("inst_rdata",  inst_rdata,  exp_ird);
    chk("data_rvalid", data_rvalid, exp_drv);
    chk("data_rdata",  data_rdata,  exp_drd);
    obs_inst_gnts += int'(inst_gnt);

    exp_irv = (pend_kind == 1) && !inst_flush;
    if (exp_irv) exp_ird = pend_word;
    exp_drv = (pend_kind == 2);
    if (exp_drv) exp_drd = pend_word;

    ii = int'(inst_addr[9:2]);
    di = int'(data_addr[9:2]);
    pend_kind = 0;
    if (gi) begin
      pend_kind = 1;
      pend_word = shadow[ii];
    end else if (gd && !data_wr) begin
      pend_kind = 2;
      pend_word = shadow[di];
    end else if (gd) begin
      word = shadow[di];
      for (int b = 0; b < 4; b++)
        if (data_wen[b]) word[8*b +: 8] = data_wdata[8*b +: 8];
      shadow[di] = word;
    end
    if (gd && inst_req) fetch_waited = (fetch_waited < SMAX) ? fetch_waited + 1 : SMAX;
    else                fetch_waited = 0;
    last_gi = gi;
    last_gd = gd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_F000) | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    model_reset();
    obs_inst_gnts = 0;
    last_gi = 1'b0;
    last_gd = 1'b0;
    reset      = 1'b1;
    inst_req   = 1'b0; inst_addr = '0; inst_flush = 1'b0;
    data_req   = 1'b0; data_wr   = 1'b0; data_wen  = '0;
    data_addr  = '0;   data_wdata = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Lone fetches on consecutive cycles.
    for (int k = 0; k < 3; k++) begin
      inst_req  = 1'b1;
      inst_addr = 32'hBFC0_0000 + 32'(4 * k);
      cycle();
    end
    inst_req = 1'b0;
    repeat (2) cycle();

    // Both requesters pinned high: fetch must win every fifth cycle.
    obs_inst_gnts = 0;
    inst_req  = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req  = 1'b1; data_wr   = 1'b0; data_addr = 32'h0000_0020;
    repeat (12) cycle();
    chk("starve_inst_grants", obs_inst_gnts, 2);
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (2) cycle();

    // Partial store then load of the same word.
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100;
    data_wen = 4'b0011; data_wdata = 32'hAABB_CCDD;
    cycle();
    data_wr = 1'b0; data_wen = 4'b0000; data_wdata = 32'h0;
    cycle();
    data_req = 1'b0;
    repeat (2) cycle();

    // Fetch response cancelled by a redirect in the response cycle.
    inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
    cycle();
    inst_req = 1'b0; inst_flush = 1'b1;
    cycle();
    inst_flush = 1'b0;
    repeat (2) cycle();

    // Reset lands while a load response is outstanding.
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0008;
    cycle();
    inst_req = 1'b1; inst_addr = 32'h40;
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    inst_req = 1'b0;
    data_req = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    data_req = 1'b1; data_addr = 32'h0000_000C;
    cycle();
    data_req = 1'b0;
    repeat (2) cycle();

    // Randomized traffic with requests held until granted.
    for (int n = 0; n < 600; n++) begin
      if (!inst_req || last_gi) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = rand_addr();
      end
      if (!data_req || last_gd) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = $urandom_range(0, 1) == 1;
        data_wen   = 4'($urandom_range(0, 15));
        data_addr  = rand_addr();
        data_wdata = $urandom;
      end
      inst_flush = ($urandom_range(0, 4) == 0);
      cycle();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    inst_flush = 1'b0;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
